// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises Rx, times 16x oversampled bits and
// emits shift/load_buffer strobes. Define RX_CTRL_MAJORITY_EN for 2-of-3 voting.
module uart_rx_ctrl #(
    parameter int unsigned CLK_DIV   = 27,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic CLOCK,
    input  logic reset,
    input  logic Rx,
    input  logic rx_en,
    input  logic clr_ferr,
    output logic rx_bit,
    output logic shift,
    output logic load_buffer,
    output logic busy,
    output logic framing_err
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned SAMP_W = 4;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rx_meta;
    logic                r_rx_s;
    logic [DIV_W-1:0]    r_div;
    logic [SAMP_W-1:0]   r_samp;
    logic [BIT_W-1:0]    r_bit;
    logic                r_rx_bit;
    logic                r_shift;
    logic                r_load;
    logic                r_busy;
    logic                r_ferr;

    logic                w_tick;
    logic                w_decide;
    logic                w_sample;
    logic                w_start;
    logic                w_shift_nxt;
    logic                w_load_nxt;
    logic                w_ferr_set;
    logic                w_bit_inc;
    logic                w_bit_clr;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

`ifdef RX_CTRL_MAJORITY_EN
    logic r_s6;
    logic r_s7;

    // Early samples held for the vote taken at the sample-8 tick.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_s6 <= 1'b1;
            r_s7 <= 1'b1;
        end else if (w_tick) begin
            if (r_samp == SAMP_W'(6)) r_s6 <= r_rx_s;
            if (r_samp == SAMP_W'(7)) r_s7 <= r_rx_s;
        end
    end

    assign w_decide = w_tick && (r_samp == SAMP_W'(8));
    assign w_sample = (r_s6 & r_s7) | (r_s6 & r_rx_s) | (r_s7 & r_rx_s);
`else
    assign w_decide = w_tick && (r_samp == SAMP_W'(7));
    assign w_sample = r_rx_s;
`endif

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and strobe decisions; disabling always wins over sampling.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift_nxt = 1'b0;
        w_load_nxt  = 1'b0;
        w_ferr_set  = 1'b0;
        w_bit_inc   = 1'b0;
        w_bit_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_en && !r_rx_s) begin
                    w_state_nxt = ST_START;
                    w_start     = 1'b1;
                end
            end
            ST_START: begin
                if (!rx_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_decide) begin
                    if (!w_sample) begin
                        w_state_nxt = ST_DATA;
                        w_bit_clr   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (!rx_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_decide) begin
                    w_shift_nxt = 1'b1;
                    if (r_bit == BIT_W'(DATA_BITS - 1)) w_state_nxt = ST_STOP;
                    else                                w_bit_inc   = 1'b1;
                end
            end
            ST_STOP: begin
                if (!rx_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_decide) begin
                    w_state_nxt = ST_IDLE;
                    if (w_sample) w_load_nxt = 1'b1;
                    else          w_ferr_set = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Oversample timing: divider held at zero while idle, restarted on the start edge.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_div  <= '0;
            r_samp <= '0;
            r_bit  <= '0;
        end else begin
            if (w_start || (r_state == ST_IDLE) || w_tick) r_div <= '0;
            else                                           r_div <= r_div + DIV_W'(1);

            if (w_start)     r_samp <= '0;
            else if (w_tick) r_samp <= r_samp + SAMP_W'(1);

            if (w_bit_clr)      r_bit <= '0;
            else if (w_bit_inc) r_bit <= r_bit + BIT_W'(1);
        end
    end

    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            r_rx_bit <= 1'b0;
            r_shift  <= 1'b0;
            r_load   <= 1'b0;
            r_busy   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_shift <= w_shift_nxt;
            r_load  <= w_load_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_shift_nxt) r_rx_bit <= w_sample;
            if (w_ferr_set)    r_ferr <= 1'b1;
            else if (clr_ferr) r_ferr <= 1'b0;
        end
    end

    assign rx_bit      = r_rx_bit;
    assign shift       = r_shift;
    assign load_buffer = r_load;
    assign busy        = r_busy;
    assign framing_err = r_ferr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLK_DIV=4, DATA_BITS=8 (64 cycles per bit).
module tb_uart_rx_ctrl;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned DATA_BITS = 8;
    localparam int          BIT_CYC   = 64;

    logic CLOCK = 1'b0;
    logic reset;
    logic Rx;
    logic rx_en;
    logic clr_ferr;
    logic rx_bit;
    logic shift;
    logic load_buffer;
    logic busy;
    logic framing_err;

    int n_cmp = 0;
    int n_err = 0;

    int   cyc       = 0;
    int   n_shift   = 0;
    int   n_load    = 0;
    int   n_overlap = 0;
    logic mon_bits [256];
    int   mon_cyc  [256];

    uart_rx_ctrl #(.CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS)) dut (
        .CLOCK       (CLOCK),
        .reset       (reset),
        .Rx          (Rx),
        .rx_en       (rx_en),
        .clr_ferr    (clr_ferr),
        .rx_bit      (rx_bit),
        .shift       (shift),
        .load_buffer (load_buffer),
        .busy        (busy),
        .framing_err (framing_err)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Event recorder sampled on the falling edge, away from the active edge.
    always @(negedge CLOCK) begin
        if (!reset) begin
            if (shift && n_shift < 256) begin
                mon_bits[n_shift] = rx_bit;
                mon_cyc[n_shift]  = cyc;
                n_shift = n_shift + 1;
            end
            if (load_buffer) n_load = n_load + 1;
            if (shift && load_buffer) n_overlap = n_overlap + 1;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        Rx = b;
        if (glitch) begin
            wait_cycles(30);
            Rx = 1'b1;
            wait_cycles(4);
            Rx = b;
            wait_cycles(BIT_CYC - 34);
        end else begin
            wait_cycles(BIT_CYC);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch);
        send_bit(stop, 1'b0);
        Rx = 1'b1;
    endtask

    task automatic get_byte(input int base, output logic [7:0] v);
        for (int i = 0; i < 8; i++) v[i] = mon_bits[base + i];
    endtask

    task automatic test_reset();
        reset = 1'b1; Rx = 1'b1; rx_en = 1'b1; clr_ferr = 1'b0;
        wait_cycles(3);
        #1;
        n_cmp++; if (shift !== 1'b0)       begin n_err++; $display("FAIL reset_shift got=%b exp=0", shift); end
        n_cmp++; if (load_buffer !== 1'b0) begin n_err++; $display("FAIL reset_load got=%b exp=0", load_buffer); end
        n_cmp++; if (busy !== 1'b0)        begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (framing_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got=%b exp=0", framing_err); end
        n_cmp++; if (rx_bit !== 1'b0)      begin n_err++; $display("FAIL reset_rxbit got=%b exp=0", rx_bit); end
        @(negedge CLOCK);
        reset = 1'b0;
        wait_cycles(10);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_good_frame();
        int bs, bl, gap;
        logic [7:0] v;
        bs = n_shift; bl = n_load;
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_cycles(40);
        n_cmp++; if (n_shift - bs !== 8) begin n_err++; $display("FAIL a5_shifts got=%0d exp=8", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 1)  begin n_err++; $display("FAIL a5_loads got=%0d exp=1", n_load - bl); end
        n_cmp++; if (framing_err !== 1'b0) begin n_err++; $display("FAIL a5_ferr got=%b exp=0", framing_err); end
        get_byte(bs, v);
        n_cmp++; if (v !== 8'hA5) begin n_err++; $display("FAIL a5_bits got=%h exp=a5", v); end
        for (int i = 1; i < 8; i++) begin
            gap = mon_cyc[bs + i] - mon_cyc[bs + i - 1];
            n_cmp++; if (gap !== BIT_CYC) begin n_err++; $display("FAIL a5_gap%0d got=%0d exp=%0d", i, gap, BIT_CYC); end
        end
    endtask

    task automatic test_false_start();
        int bs, bl;
        bs = n_shift; bl = n_load;
        Rx = 1'b0;
        wait_cycles(8);
        Rx = 1'b1;
        wait_cycles(2);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fs_busy_hi got=%b exp=1", busy); end
        wait_cycles(60);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fs_busy_lo got=%b exp=0", busy); end
        n_cmp++; if (n_shift - bs !== 0) begin n_err++; $display("FAIL fs_shifts got=%0d exp=0", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 0)  begin n_err++; $display("FAIL fs_loads got=%0d exp=0", n_load - bl); end
    endtask

    task automatic test_framing_err();
        int bs, bl;
        logic [7:0] v;
        bs = n_shift; bl = n_load;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_cycles(150);
        n_cmp++; if (n_shift - bs !== 8) begin n_err++; $display("FAIL fe_shifts got=%0d exp=8", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 0)  begin n_err++; $display("FAIL fe_loads got=%0d exp=0", n_load - bl); end
        n_cmp++; if (framing_err !== 1'b1) begin n_err++; $display("FAIL fe_set got=%b exp=1", framing_err); end
        get_byte(bs, v);
        n_cmp++; if (v !== 8'h3C) begin n_err++; $display("FAIL fe_bits got=%h exp=3c", v); end
        wait_cycles(20);
        n_cmp++; if (framing_err !== 1'b1) begin n_err++; $display("FAIL fe_sticky got=%b exp=1", framing_err); end
        clr_ferr = 1'b1;
        wait_cycles(1);
        clr_ferr = 1'b0;
        wait_cycles(2);
        n_cmp++; if (framing_err !== 1'b0) begin n_err++; $display("FAIL fe_clear got=%b exp=0", framing_err); end
    endtask

    task automatic test_back_to_back();
        int bs, bl;
        logic [7:0] v;
        bs = n_shift; bl = n_load;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        wait_cycles(40);
        n_cmp++; if (n_shift - bs !== 16) begin n_err++; $display("FAIL b2b_shifts got=%0d exp=16", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 2)   begin n_err++; $display("FAIL b2b_loads got=%0d exp=2", n_load - bl); end
        get_byte(bs, v);
        n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL b2b_byte0 got=%h exp=00", v); end
        get_byte(bs + 8, v);
        n_cmp++; if (v !== 8'hFF) begin n_err++; $display("FAIL b2b_byte1 got=%h exp=ff", v); end
        n_cmp++; if (n_overlap !== 0) begin n_err++; $display("FAIL overlap got=%0d exp=0", n_overlap); end
    endtask

    task automatic test_reset_midframe();
        int bs, bl;
        logic [7:0] v;
        logic [7:0] d;
        d  = 8'h55;
        bs = n_shift; bl = n_load;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i], 1'b0);
        n_cmp++; if (n_shift - bs !== 3) begin n_err++; $display("FAIL rm_pre_shifts got=%0d exp=3", n_shift - bs); end
        reset = 1'b1;
        Rx    = 1'b1;
        #1;
        n_cmp++; if ({shift, load_buffer, busy, framing_err, rx_bit} !== 5'b0)
            begin n_err++; $display("FAIL rm_outs got=%b exp=00000", {shift, load_buffer, busy, framing_err, rx_bit}); end
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(700);
        n_cmp++; if (n_load - bl !== 0) begin n_err++; $display("FAIL rm_no_load got=%0d exp=0", n_load - bl); end
        bs = n_shift; bl = n_load;
        send_frame(d, 1'b1, 1'b0);
        wait_cycles(40);
        n_cmp++; if (n_shift - bs !== 8) begin n_err++; $display("FAIL rm_shifts got=%0d exp=8", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 1)  begin n_err++; $display("FAIL rm_loads got=%0d exp=1", n_load - bl); end
        get_byte(bs, v);
        n_cmp++; if (v !== 8'h55) begin n_err++; $display("FAIL rm_bits got=%h exp=55", v); end
    endtask

    task automatic test_disable();
        int bs, bl;
        logic [7:0] d;
        d  = 8'h5A;
        bs = n_shift; bl = n_load;
        send_bit(1'b0, 1'b0);
        send_bit(d[0], 1'b0);
        send_bit(d[1], 1'b0);
        Rx = d[2];
        wait_cycles(20);
        rx_en = 1'b0;
        wait_cycles(3);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dis_busy got=%b exp=0", busy); end
        wait_cycles(BIT_CYC - 23);
        for (int i = 3; i < 8; i++) send_bit(d[i], 1'b0);
        send_bit(1'b1, 1'b0);
        Rx = 1'b1;
        wait_cycles(10);
        rx_en = 1'b1;
        wait_cycles(10);
        n_cmp++; if (n_shift - bs !== 2) begin n_err++; $display("FAIL dis_shifts got=%0d exp=2", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 0)  begin n_err++; $display("FAIL dis_loads got=%0d exp=0", n_load - bl); end
    endtask

    task automatic test_glitch();
        int bs, bl;
        logic [7:0] v;
        logic [7:0] exp_v;
`ifdef RX_CTRL_MAJORITY_EN
        exp_v = 8'h00;
`else
        exp_v = 8'hFF;
`endif
        bs = n_shift; bl = n_load;
        send_frame(8'h00, 1'b1, 1'b1);
        wait_cycles(40);
        n_cmp++; if (n_shift - bs !== 8) begin n_err++; $display("FAIL gl_shifts got=%0d exp=8", n_shift - bs); end
        n_cmp++; if (n_load - bl !== 1)  begin n_err++; $display("FAIL gl_loads got=%0d exp=1", n_load - bl); end
        get_byte(bs, v);
        n_cmp++; if (v !== exp_v) begin n_err++; $display("FAIL gl_bits got=%h exp=%h", v, exp_v); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_false_start();
        test_framing_err();
        test_back_to_back();
        test_reset_midframe();
        test_disable();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
